// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter handshake bundle for uart_tx_fifo.
// The Overflow signal exists only when UART_FIFO_OVERFLOW_FLAG_EN is defined.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
);
    logic                  WriteEnable;
    logic [WIDTH-1:0]      WriteData;
    logic                  Full;
    logic                  ReadEnable;
    logic [WIDTH-1:0]      DataOut;
    logic                  DataValid;
    logic                  Empty;
    logic [DEPTH_LOG2:0]   Count;
`ifdef UART_FIFO_OVERFLOW_FLAG_EN
    logic                  Overflow;
`endif

    modport master (
        output WriteEnable, WriteData, ReadEnable,
`ifdef UART_FIFO_OVERFLOW_FLAG_EN
        input  Overflow,
`endif
        input  Full, DataOut, DataValid, Empty, Count
    );

    modport slave (
        input  WriteEnable, WriteData, ReadEnable,
`ifdef UART_FIFO_OVERFLOW_FLAG_EN
        output Overflow,
`endif
        output Full, DataOut, DataValid, Empty, Count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: single-cycle writes, one-outstanding registered reads.
// Optional sticky dropped-write flag enabled by defining UART_FIFO_OVERFLOW_FLAG_EN.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input logic           Clk,
    input logic           Reset,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_next_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  valid_r;
    logic [WIDTH-1:0]      data_out_r;
    logic                  wr_accept_s;
    logic                  rd_accept_s;

    // Full/Empty are pre-edge registered values, so a full FIFO drops a same-cycle write
    // and an empty FIFO never falls a fresh write through to the reader.
    assign wr_accept_s = bus.WriteEnable & ~full_r;
    assign rd_accept_s = bus.ReadEnable & ~empty_r & ~valid_r;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        count_next_s = count_r;
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r] <= bus.WriteData;
        end
    end

    // Pointers, occupancy, flags and the registered read port.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
            count_r    <= {(DEPTH_LOG2+1){1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            valid_r    <= 1'b0;
            data_out_r <= {WIDTH{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_accept_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                data_out_r <= mem_r[rd_ptr_r];
            end
            valid_r <= rd_accept_s;
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_COUNT);
            empty_r <= (count_next_s == {(DEPTH_LOG2+1){1'b0}});
        end
    end

`ifdef UART_FIFO_OVERFLOW_FLAG_EN
    logic overflow_r;

    // Sticky record of any write attempted while full; only reset clears it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | (bus.WriteEnable & full_r);
        end
    end

    assign bus.Overflow = overflow_r;
`endif

    assign bus.Full      = full_r;
    assign bus.Empty     = empty_r;
    assign bus.Count     = count_r;
    assign bus.DataValid = valid_r;
    assign bus.DataOut   = data_out_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (works with or without UART_FIFO_OVERFLOW_FLAG_EN).
module tb_uart_tx_fifo;
    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;
    logic [7:0] rx_q [$];
    int         rx_cyc_q [$];

    uart_tx_fifo_if #(.DEPTH_LOG2(4), .WIDTH(8)) bus_if ();

    uart_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus_if.WriteEnable = 1'b1;
        bus_if.WriteData   = b;
        @(posedge Clk); #1;
        bus_if.WriteEnable = 1'b0;
    endtask

    // Hold ReadEnable for a bounded number of cycles, logging every DataValid pulse.
    task automatic run_reads(input int cycles);
        rx_q.delete();
        rx_cyc_q.delete();
        bus_if.ReadEnable = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge Clk); #1;
            if (bus_if.DataValid === 1'b1) begin
                rx_q.push_back(bus_if.DataOut);
                rx_cyc_q.push_back(c);
            end
        end
        bus_if.ReadEnable = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus_if.WriteEnable = 1'b0;
        bus_if.WriteData   = 8'h00;
        bus_if.ReadEnable  = 1'b0;
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_empty", {31'd0, bus_if.Empty}, 32'd1);
        check_eq("rst_full", {31'd0, bus_if.Full}, 32'd0);
        check_eq("rst_count", {27'd0, bus_if.Count}, 32'd0);
        check_eq("rst_valid", {31'd0, bus_if.DataValid}, 32'd0);
        check_eq("rst_dout", {24'd0, bus_if.DataOut}, 32'd0);
`ifdef UART_FIFO_OVERFLOW_FLAG_EN
        check_eq("rst_ovf", {31'd0, bus_if.Overflow}, 32'd0);
`endif
        Reset = 1'b1;

        // Idle read request on empty FIFO must never pulse.
        run_reads(10);
        check_eq("idle_pulses", rx_q.size(), 32'd0);

        // Three bytes, read back one every second cycle.
        push(8'h41); push(8'h42); push(8'h43);
        check_eq("w3_count", {27'd0, bus_if.Count}, 32'd3);
        check_eq("w3_empty", {31'd0, bus_if.Empty}, 32'd0);
        run_reads(12);
        check_eq("r3_pulses", rx_q.size(), 32'd3);
        for (int i = 0; i < rx_q.size(); i++) begin
            check_eq($sformatf("r3_data%0d", i), {24'd0, rx_q[i]}, 32'h41 + i);
        end
        for (int i = 1; i < rx_cyc_q.size(); i++) begin
            check_eq($sformatf("r3_gap%0d", i), rx_cyc_q[i] - rx_cyc_q[i-1], 32'd2);
        end
        check_eq("r3_empty", {31'd0, bus_if.Empty}, 32'd1);

        // Fill to depth, drop a 17th write, then drain.
        for (int i = 0; i < 16; i++) push(i[7:0]);
        check_eq("fill_full", {31'd0, bus_if.Full}, 32'd1);
        check_eq("fill_count", {27'd0, bus_if.Count}, 32'd16);
        push(8'hFF);
        check_eq("drop_count", {27'd0, bus_if.Count}, 32'd16);
        check_eq("drop_full", {31'd0, bus_if.Full}, 32'd1);
`ifdef UART_FIFO_OVERFLOW_FLAG_EN
        check_eq("drop_ovf", {31'd0, bus_if.Overflow}, 32'd1);
`endif
        run_reads(40);
        check_eq("drain_pulses", rx_q.size(), 32'd16);
        for (int i = 0; i < rx_q.size(); i++) begin
            check_eq($sformatf("drain_data%0d", i), {24'd0, rx_q[i]}, i);
        end
        check_eq("drain_empty", {31'd0, bus_if.Empty}, 32'd1);
`ifdef UART_FIFO_OVERFLOW_FLAG_EN
        check_eq("ovf_sticky", {31'd0, bus_if.Overflow}, 32'd1);
`endif

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) push(8'h10 + i[7:0]);
        run_reads(24);
        check_eq("wrapA_pulses", rx_q.size(), 32'd10);
        for (int i = 0; i < 12; i++) push(8'h80 + i[7:0]);
        check_eq("wrapB_count", {27'd0, bus_if.Count}, 32'd12);
        run_reads(30);
        check_eq("wrapB_pulses", rx_q.size(), 32'd12);
        for (int i = 0; i < rx_q.size(); i++) begin
            check_eq($sformatf("wrap_data%0d", i), {24'd0, rx_q[i]}, 32'h80 + i);
        end

        // Full with simultaneous write and read: read wins, write dropped.
        for (int i = 0; i < 16; i++) push(8'h20 + i[7:0]);
        bus_if.WriteEnable = 1'b1;
        bus_if.WriteData   = 8'h55;
        bus_if.ReadEnable  = 1'b1;
        @(posedge Clk); #1;
        bus_if.WriteEnable = 1'b0;
        bus_if.ReadEnable  = 1'b0;
        check_eq("fwr_valid", {31'd0, bus_if.DataValid}, 32'd1);
        check_eq("fwr_data", {24'd0, bus_if.DataOut}, 32'h20);
        check_eq("fwr_count", {27'd0, bus_if.Count}, 32'd15);
        check_eq("fwr_full", {31'd0, bus_if.Full}, 32'd0);
        run_reads(40);
        check_eq("fwr_pulses", rx_q.size(), 32'd15);
        if (rx_q.size() > 0) check_eq("fwr_last", {24'd0, rx_q[rx_q.size()-1]}, 32'h2F);

        // Asynchronous reset while a read is in flight.
        for (int i = 0; i < 6; i++) push(8'hA0 + i[7:0]);
        bus_if.ReadEnable = 1'b1;
        @(posedge Clk); #1;
        bus_if.ReadEnable = 1'b0;
        check_eq("pre_rst_count", {27'd0, bus_if.Count}, 32'd5);
        check_eq("pre_rst_valid", {31'd0, bus_if.DataValid}, 32'd1);
        #1 Reset = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, bus_if.DataValid}, 32'd0);
        check_eq("arst_count", {27'd0, bus_if.Count}, 32'd0);
        check_eq("arst_empty", {31'd0, bus_if.Empty}, 32'd1);
        check_eq("arst_full", {31'd0, bus_if.Full}, 32'd0);
        check_eq("arst_dout", {24'd0, bus_if.DataOut}, 32'd0);
`ifdef UART_FIFO_OVERFLOW_FLAG_EN
        check_eq("arst_ovf", {31'd0, bus_if.Overflow}, 32'd0);
`endif
        @(posedge Clk); #1;
        Reset = 1'b1;
        run_reads(8);
        check_eq("post_rst_pulses", rx_q.size(), 32'd0);
        check_eq("post_rst_empty", {31'd0, bus_if.Empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synchronous byte FIFO sitting directly upstream of the UART transmitter in the UARTLedSystem datapath. Producers (receive/echo logic, LED status formatter) push bytes with a single-cycle write strobe. The transmitter pulls bytes through a registered read handshake that returns one byte per request, together with a one-cycle `DataValid` pulse. The block decouples bursty producers from the 868-cycle-per-bit serial line.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: log2 of storage depth; depth = 16 entries.
- `WIDTH`, 8: data width in bits.

Ports:
- `Clk`  input  1  system clock; all state changes on rising edge.
- `Reset`  input  1  asynchronous, active-low reset (asserted = 0).
- `WriteEnable`  input  1  producer write strobe, sampled each cycle.
- `WriteData`  input  WIDTH  byte to store.
- `Full`  output  1  registered; high when Count == depth.
- `ReadEnable`  input  1  level read request from the transmitter.
- `DataOut`  output  WIDTH  registered read data; valid only while `DataValid` = 1.
- `DataValid`  output  1  one-cycle pulse, the cycle after a read is accepted.
- `Empty`  output  1  registered; high when Count == 0.
- `Count`  output  DEPTH_LOG2+1  current occupancy, 0..depth.
- `Overflow`  output  1  sticky dropped-write flag; present only with the macro (see Configuration).

## Operation
- Storage: register array of depth × WIDTH. Write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo depth (15 → 0).
- Write accepted when `WriteEnable` & !`Full`, both sampled at the edge. On acceptance, store `WriteData` at the write pointer and increment the pointer.
- Write with `Full` = 1 is dropped. Memory and pointers are unchanged.
- Read accepted when `ReadEnable` & !`Empty` & !`DataValid`.
  - The `!DataValid` term limits the block to one outstanding read.
  - The transmitter holds `ReadEnable` high until it sees `DataValid`. It must not get a second pop in the cycle it drops the request.
- On an accepted read:
  - `DataOut` ← mem[read pointer].
  - Read pointer increments.
  - `DataValid` = 1 for exactly the next cycle.
- Count update:
  - +1 on a write alone.
  - −1 on a read alone.
  - Unchanged on a simultaneous accepted read and write.
- `Empty` and `Full` are derived from the next value of Count and registered, so they are exact in the cycle after the update.
- `Full` & read & write in the same cycle: the read is accepted, the write is dropped (Full is pre-edge). Count decrements.
- `Empty` & write & `ReadEnable` in the same cycle: the write is accepted, the read is not (no fall-through). The read is accepted on the next edge.
- No state machine. Control state is pointers, Count, and the `DataValid` register.

## Timing
- Reset (Reset = 0, asynchronous): pointers 0, Count 0, `Empty` 1, `Full` 0, `DataValid` 0, `DataOut` 0, `Overflow` 0. Memory contents are not reset.
- Reset asserted mid-operation: all stored data is discarded immediately. A pending `DataValid` is cleared without completing.
- Write-to-visible latency: a write at edge N gives `Empty` = 0 after edge N. The earliest accepted read is at edge N+1, with `DataValid` high after it.
- Read latency: request accepted at edge N; `DataOut`/`DataValid` valid from edge N to edge N+1.
- Throughput: at most one read every 2 cycles, which far exceeds the transmitter's demand. One write per cycle.

## Configuration
- `UART_FIFO_OVERFLOW_FLAG_EN` defined:
  - The `Overflow` port exists.
  - It sets to 1 on any cycle where `WriteEnable` & `Full`.
  - It holds until Reset. It is not cleared by reads.
- Not defined: the `Overflow` port and its register are absent. Dropped writes are silent. All other behaviour is identical.

## Test plan
- Reset then idle: `Empty` = 1, `Full` = 0, `Count` = 0, `DataValid` = 0. Hold `ReadEnable` = 1 for 10 cycles → `DataValid` never pulses.
- Write 0x41, 0x42, 0x43 on consecutive cycles, then hold `ReadEnable` high → `DataValid` pulses every 2nd cycle with 0x41, 0x42, 0x43 in order. `Empty` = 1 after the third pulse, with exactly 3 pulses.
- Write 16 bytes 0x00..0x0F → `Full` = 1, `Count` = 16. A 17th write of 0xFF is dropped. Draining returns 0x00..0x0F; `Overflow` = 1 when the macro is defined.
- Wrap-around: 10 writes, 10 reads, then 12 writes (0x80..0x8B) and 12 reads → data returns 0x80..0x8B in order across the pointer wrap.
- When `Full`, simultaneous write of 0x55 and `ReadEnable` → the oldest byte is read, 0x55 is dropped, `Count` = 15.
- Assert Reset while `Count` = 5 and `DataValid` is high → all outputs go to reset values asynchronously. After release, `Empty` = 1 and no `DataValid` pulse occurs.
